cordic_shift_accumulate: RTL and testbench

- One pipeline stage (micro-rotation) of a 16-stage rotation-mode CORDIC datapath.
- The STAGE parameter selects the shift amount and the arctangent constant. Instances with STAGE=0, 1 and 10 replace the per-index stage modules.
- Sixteen instances are chained x_out->x, y_out->y, z_out->z, indices 0..15, to rotate vector (x0,y0) by angle z0.
- Every stage is fully registered: one new sample per clock, one cycle per stage.

---
 rtl/cordic_shift_accumulate.sv | 51 +++++
 tb/tb_cordic_shift_accumulate.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cordic_shift_accumulate.sv
// cordic_shift_accumulate: one registered micro-rotation stage of a rotation-mode CORDIC
module cordic_shift_accumulate #(
    parameter int STAGE = 0,
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    input  logic signed [WIDTH-1:0] z,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out
);
    localparam int ATAN = STAGE == 0 ? 804 : STAGE == 1 ? 474 : STAGE == 2 ? 250 :
                          STAGE == 3 ? 127 : STAGE == 4 ? 63  : STAGE == 5 ? 31  :
                          STAGE == 6 ? 15  : STAGE == 7 ? 7   : STAGE == 8 ? 3   :
                          STAGE == 9 ? 1   : 0;
    localparam logic signed [WIDTH-1:0] A = WIDTH'(ATAN);

    if (STAGE < 0 || STAGE > 15) begin : g_bad_stage
        $fatal(1, "cordic_shift_accumulate: STAGE must be in 0..15");
    end

    logic signed [WIDTH-1:0] xs, ys, x_nxt, y_nxt, z_nxt;
    logic pos;

    assign xs = x >>> STAGE;
    assign ys = y >>> STAGE;

    // rotate toward zero residual angle; z == 0 counts as non-negative
    always_comb begin
        pos   = ~z[WIDTH-1];
        x_nxt = pos ? x - ys : x + ys;
        y_nxt = pos ? y + xs : y - xs;
        z_nxt = pos ? z - A  : z + A;
    end

    // capture every cycle; reset clears the stage asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_out <= '0;
            y_out <= '0;
            z_out <= '0;
        end else begin
            x_out <= x_nxt;
            y_out <= y_nxt;
            z_out <= z_nxt;
        end
    end
endmodule

// File: tb/tb_cordic_shift_accumulate.sv
// tb_cordic_shift_accumulate: scoreboard bench over stages 0, 1, 9 and 10 driven in parallel
module tb_cordic_shift_accumulate;
    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic [31:0] x = '0, y = '0, z = '0;
    logic [31:0] xo[4], yo[4], zo[4];
    exp_t        q[4][$];
    int          ncmp = 0, nerr = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        cordic_shift_accumulate #(
            .STAGE(g == 0 ? 0 : g == 1 ? 1 : g == 2 ? 9 : 10),
            .WIDTH(32)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .x    (x),
            .y    (y),
            .z    (z),
            .x_out(xo[g]),
            .y_out(yo[g]),
            .z_out(zo[g])
        );
    end

    function automatic int stage_of(int k);
        return k == 0 ? 0 : k == 1 ? 1 : k == 2 ? 9 : 10;
    endfunction

    function automatic exp_t model(int i, logic signed [31:0] a, logic signed [31:0] b, logic signed [31:0] c);
        int at[16] = '{804, 474, 250, 127, 63, 31, 15, 7, 3, 1, 0, 0, 0, 0, 0, 0};
        logic signed [31:0] sa, sb, ang;
        exp_t r;
        sa = a >>> i;
        sb = b >>> i;
        ang = at[i];
        if (c < 0) begin
            r.x = a + sb;
            r.y = b - sa;
            r.z = c + ang;
        end else begin
            r.x = a - sb;
            r.y = b + sa;
            r.z = c - ang;
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(logic [31:0] a, logic [31:0] b, logic [31:0] c);
        @(negedge clk);
        x = a;
        y = b;
        z = c;
        vld = 1'b1;
        for (int k = 0; k < 4; k++) q[k].push_back(model(stage_of(k), a, b, c));
    endtask

    task automatic idle();
        @(negedge clk);
        vld = 1'b0;
    endtask

    // pop one expected result per stage for every valid edge
    always @(posedge clk) begin
        if (vld && rst_n) begin
            #1;
            for (int k = 0; k < 4; k++) begin
                if (q[k].size() == 0) begin
                    chk($sformatf("sb_empty_s%0d", stage_of(k)), 32'd0, 32'd1);
                end else begin
                    exp_t e;
                    e = q[k].pop_front();
                    chk($sformatf("x_s%0d", stage_of(k)), xo[k], e.x);
                    chk($sformatf("y_s%0d", stage_of(k)), yo[k], e.y);
                    chk($sformatf("z_s%0d", stage_of(k)), zo[k], e.z);
                end
            end
        end
    end

    task automatic chk_zero(string tag);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_x"}, xo[k], 32'd0);
            chk({tag, "_y"}, yo[k], 32'd0);
            chk({tag, "_z"}, zo[k], 32'd0);
        end
    endtask

    initial begin
        #1;
        chk_zero("rst_init");
        @(negedge clk);
        rst_n = 1'b1;

        send(32'd1000, 32'd0, 32'd100);
        @(posedge clk); #2;
        chk("s0_x", xo[0], 32'd1000);
        chk("s0_y", yo[0], 32'd1000);
        chk("s0_z", zo[0], -32'sd704);

        send(32'd1000, 32'd1000, -32'sd704);
        @(posedge clk); #2;
        chk("s1_x", xo[1], 32'd1500);
        chk("s1_y", yo[1], 32'd500);
        chk("s1_z", zo[1], -32'sd230);

        send(-32'sd1024, 32'd2048, 32'd0);
        @(posedge clk); #2;
        chk("s10_x", xo[3], -32'sd1026);
        chk("s10_y", yo[3], 32'd2047);
        chk("s10_z", zo[3], 32'd0);

        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        @(posedge clk); #2;
        chk("s9_x", xo[2], 32'd0);
        chk("s9_y", yo[2], -32'sd2);
        chk("s9_z", zo[2], -32'sd1);

        send(32'h7FFF_FFFF, 32'd1, 32'd5);
        @(posedge clk); #2;
        chk("wrap_x", xo[0], 32'h7FFF_FFFE);
        chk("wrap_y", yo[0], 32'h8000_0000);
        chk("wrap_z", zo[0], -32'sd799);

        for (int n = 0; n < 24; n++) send($urandom, $urandom, $urandom);
        send(32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        send(32'd0, 32'd0, 32'hFFFF_FFFF);
        idle();

        @(negedge clk);
        x = 32'h1234_5678;
        y = 32'h0BAD_F00D;
        z = 32'd77;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        @(posedge clk); #1;
        chk_zero("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_zero("rst_release");

        send(32'd300, -32'sd700, 32'd50);
        for (int n = 0; n < 8; n++) send($urandom, $urandom, $urandom);
        idle();
        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < 4; k++) chk($sformatf("sb_left_s%0d", stage_of(k)), q[k].size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
